rv_alu_decode: RTL and testbench
================================

// Module: rv_alu_decode
// PURPOSE
//  Decode stage feeding the RV32I ALU. Accepts one instruction per cycle with register operands already read.
//  Decodes OP, OP-IMM, LUI and AUIPC into the 4-bit ALU op code plus the A/B operands and rd.
//  Holds the result in one registered pipeline slot with a valid/ready handshake toward execute.
//  Flags illegal encodings and counts them.
// PARAMETERS
//  CNT_W   8   width of the saturating illegal-instruction counter
// PORTS
//  iClk         in   1      clock; all state updates on the rising edge
//  iRst         in   1      synchronous reset, active-high
//  iInstr       in   32     instruction word
//  iPC          in   32     PC of iInstr (used by AUIPC)
//  iRs1Val      in   32     rs1 register value
//  iRs2Val      in   32     rs2 register value
//  iInstrValid  in   1      upstream has an instruction
//  oInstrReady  out  1      stage can accept an instruction this cycle
//  iFlush       in   1      discard the held slot (branch redirect)
//  oValid       out  1      slot holds a decoded instruction
//  iReady       in   1      execute consumes the slot
//  oOP          out  4      ALU op (package encoding)
//  oA / oB      out  32     ALU operands
//  oRd          out  5      destination register
//  oWe          out  1      register write enable
//  oIllegal     out  1      held instruction was illegal
//  oIllegalCnt  out  CNT_W  saturating count of accepted illegal instructions
// BEHAVIOUR
//  Reset (iRst=1 at edge): oValid=0, oOP=0, oA=0, oB=0, oRd=0, oWe=0, oIllegal=0, oIllegalCnt=0. All other inputs are ignored.
//  ALU op encoding: ADD=0 SUB=1 XOR=2 OR=3 AND=4 SLL=5 SRL=6 SRA=7 SLT=8 SLTU=9. Codes 10-15 are unused.
//  Handshake and timing
//   - oInstrReady = !iFlush && (!oValid || iReady). Combinational; no skid buffer.
//   - An instruction is accepted when iInstrValid && oInstrReady. Its decode is registered at that edge.
//   - Latency is 1 cycle. Throughput is 1/cycle while iReady=1.
//   - Accept with no consumption (oValid=0): oValid<=1. Consume without accept: oValid<=0. Both together: slot replaced, oValid stays 1.
//   - oValid=1 && iReady=0: every output is held stable.
//   - iFlush=1: oValid<=0 next edge. No accept that cycle. oIllegalCnt is unchanged by the flush.
//  Decode (opcode = iInstr[6:0], f3 = [14:12], f7 = [31:25])
//   - 0110011 OP: A=rs1, B=rs2.
//       f7=0: f3 000 ADD, 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL, 110 OR, 111 AND.
//       f7=0100000: f3 000 SUB, 101 SRA. Any other f7/f3 combination is illegal.
//   - 0010011 OP-IMM: A=rs1, B=sext(iInstr[31:20]).
//       f3 000 ADD, 010 SLT, 011 SLTU, 100 XOR, 110 OR, 111 AND.
//       Shifts: B={27'b0,iInstr[24:20]}.
//         f3 001 SLL requires f7=0.
//         f3 101 SRL requires f7=0; SRA requires f7=0100000. Other f7 values are illegal.
//   - 0110111 LUI: op=ADD, A=0, B={iInstr[31:12],12'b0}.
//   - 0010111 AUIPC: op=ADD, A=iPC, B={iInstr[31:12],12'b0}.
//   - oRd=iInstr[11:7]. oWe=1 only if legal and rd!=0.
//   - Any other opcode is illegal.
//  Illegal instruction, when accepted:
//   - oValid=1, oIllegal=1, oOP=ADD, oA=0, oB=0, oWe=0.
//   - oIllegalCnt increments, saturating at 2^CNT_W-1.
//  Arithmetic: all immediates are sign/zero-extended to exactly 32 bits. There is no other width conversion.
// STRUCTURE
//  Package rv_pkg: ALU op localparams (ALU_ADD..ALU_SLTU), opcode localparams (OPC_OP, OPC_OPIMM, OPC_LUI, OPC_AUIPC),
//   and the f7 constants F7_BASE=0, F7_ALT=7'b0100000. The ALU uses the same package.
//  Sub-module rv_alu_dec_comb: purely combinational instr -> {op, A, B, rd, we, illegal}.
//   The top holds the pipeline register, the handshake and the counter.
// TESTING
//  1 ADD x3,x1,x2 (0x002081B3), rs1=5, rs2=7 -> next cycle oValid=1, oOP=0, oA=5, oB=7, oRd=3, oWe=1.
//  2 SRAI x1,x2,4 (0x40415093), rs1=0x80000000 -> oOP=7, oB=4. SLLI with f7=0100000 -> oIllegal=1, oWe=0, cnt+1.
//  3 AUIPC x5,0x12345 (0x12345297), iPC=0x100 -> oOP=0, oA=0x100, oB=0x12345000, oRd=5.
//  4 iReady=0 for 3 cycles with iInstrValid=1 -> oInstrReady=0, outputs frozen.
//    iReady=1 -> back-to-back acceptance, 1 instruction/cycle.
//  5 iFlush with oValid=1 and iInstrValid=1 -> oInstrReady=0, oValid=0 next cycle, no instruction lost upstream.
//  6 300 illegal words (0xFFFFFFFF) with CNT_W=8 -> cnt saturates at 255.
//    iRst mid-stream -> all outputs 0 next cycle.

Source files
------------

// File: rtl/rv_pkg.sv
// Shared RV32I decode/ALU constants: ALU op codes, major opcodes and funct7 values.
package rv_pkg;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_XOR  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_AND  = 4'd4;
  localparam logic [3:0] ALU_SLL  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_SLT  = 4'd8;
  localparam logic [3:0] ALU_SLTU = 4'd9;

  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  function automatic logic [31:0] sext12(input logic [11:0] imm);
    return {{20{imm[11]}}, imm};
  endfunction

endpackage

// File: rtl/rv_alu_dec_comb.sv
// Combinational RV32I decode of OP/OP-IMM/LUI/AUIPC into ALU op, operands, rd and write enable.
module rv_alu_dec_comb
  import rv_pkg::*;
(
  input  logic [31:0] instr_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] rs1_i,
  input  logic [31:0] rs2_i,
  output logic [3:0]  op_o,
  output logic [31:0] a_o,
  output logic [31:0] b_o,
  output logic [4:0]  rd_o,
  output logic        we_o,
  output logic        illegal_o
);

  logic [6:0]  opcode;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [31:0] shamt;
  logic [31:0] upper;
  logic        illegal;

  assign opcode = instr_i[6:0];
  assign f3     = instr_i[14:12];
  assign f7     = instr_i[31:25];
  assign shamt  = {27'b0, instr_i[24:20]};
  assign upper  = {instr_i[31:12], 12'b0};

  always_comb begin
    op_o    = ALU_ADD;
    a_o     = '0;
    b_o     = '0;
    illegal = 1'b0;
    case (opcode)
      OPC_OP: begin
        a_o = rs1_i;
        b_o = rs2_i;
        if (f7 == F7_BASE) begin
          case (f3)
            3'b000:  op_o = ALU_ADD;
            3'b001:  op_o = ALU_SLL;
            3'b010:  op_o = ALU_SLT;
            3'b011:  op_o = ALU_SLTU;
            3'b100:  op_o = ALU_XOR;
            3'b101:  op_o = ALU_SRL;
            3'b110:  op_o = ALU_OR;
            default: op_o = ALU_AND;
          endcase
        end else if (f7 == F7_ALT && f3 == 3'b000) begin
          op_o = ALU_SUB;
        end else if (f7 == F7_ALT && f3 == 3'b101) begin
          op_o = ALU_SRA;
        end else begin
          illegal = 1'b1;
        end
      end
      OPC_OPIMM: begin
        a_o = rs1_i;
        b_o = sext12(instr_i[31:20]);
        case (f3)
          3'b000: op_o = ALU_ADD;
          3'b010: op_o = ALU_SLT;
          3'b011: op_o = ALU_SLTU;
          3'b100: op_o = ALU_XOR;
          3'b110: op_o = ALU_OR;
          3'b111: op_o = ALU_AND;
          3'b001: begin
            b_o     = shamt;
            op_o    = ALU_SLL;
            illegal = (f7 != F7_BASE);
          end
          default: begin
            b_o = shamt;
            if (f7 == F7_BASE) begin
              op_o = ALU_SRL;
            end else if (f7 == F7_ALT) begin
              op_o = ALU_SRA;
            end else begin
              illegal = 1'b1;
            end
          end
        endcase
      end
      OPC_LUI: begin
        b_o = upper;
      end
      OPC_AUIPC: begin
        a_o = pc_i;
        b_o = upper;
      end
      default: illegal = 1'b1;
    endcase
    // Illegal words present a neutral ADD 0,0 downstream.
    if (illegal) begin
      op_o = ALU_ADD;
      a_o  = '0;
      b_o  = '0;
    end
  end

  assign rd_o      = instr_i[11:7];
  assign we_o      = !illegal && (instr_i[11:7] != 5'd0);
  assign illegal_o = illegal;

endmodule

// File: rtl/rv_alu_decode.sv
// Decode stage toward the ALU: one registered output slot with valid/ready, flush and
// a saturating count of accepted illegal instructions.
module rv_alu_decode
  import rv_pkg::*;
#(
  parameter int unsigned CNT_W = 8
) (
  input  logic             iClk,
  input  logic             iRst,
  input  logic [31:0]      iInstr,
  input  logic [31:0]      iPC,
  input  logic [31:0]      iRs1Val,
  input  logic [31:0]      iRs2Val,
  input  logic             iInstrValid,
  output logic             oInstrReady,
  input  logic             iFlush,
  output logic             oValid,
  input  logic             iReady,
  output logic [3:0]       oOP,
  output logic [31:0]      oA,
  output logic [31:0]      oB,
  output logic [4:0]       oRd,
  output logic             oWe,
  output logic             oIllegal,
  output logic [CNT_W-1:0] oIllegalCnt
);

  logic [3:0]  dec_op;
  logic [31:0] dec_a;
  logic [31:0] dec_b;
  logic [4:0]  dec_rd;
  logic        dec_we;
  logic        dec_illegal;

  rv_alu_dec_comb u_dec (
    .instr_i   (iInstr),
    .pc_i      (iPC),
    .rs1_i     (iRs1Val),
    .rs2_i     (iRs2Val),
    .op_o      (dec_op),
    .a_o       (dec_a),
    .b_o       (dec_b),
    .rd_o      (dec_rd),
    .we_o      (dec_we),
    .illegal_o (dec_illegal)
  );

  logic             valid_q, valid_d;
  logic [3:0]       op_q, op_d;
  logic [31:0]      a_q, a_d;
  logic [31:0]      b_q, b_d;
  logic [4:0]       rd_q, rd_d;
  logic             we_q, we_d;
  logic             illegal_q, illegal_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             accept;

  assign oInstrReady = !iFlush && (!valid_q || iReady);
  assign accept      = iInstrValid && oInstrReady;

  always_comb begin
    valid_d   = valid_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    rd_d      = rd_q;
    we_d      = we_q;
    illegal_d = illegal_q;
    cnt_d     = cnt_q;
    if (iFlush) begin
      valid_d = 1'b0;
    end else if (accept) begin
      valid_d   = 1'b1;
      op_d      = dec_op;
      a_d       = dec_a;
      b_d       = dec_b;
      rd_d      = dec_rd;
      we_d      = dec_we;
      illegal_d = dec_illegal;
      if (dec_illegal && (cnt_q != {CNT_W{1'b1}})) begin
        cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end else if (iReady) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      valid_q   <= 1'b0;
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      rd_q      <= '0;
      we_q      <= 1'b0;
      illegal_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      valid_q   <= valid_d;
      op_q      <= op_d;
      a_q       <= a_d;
      b_q       <= b_d;
      rd_q      <= rd_d;
      we_q      <= we_d;
      illegal_q <= illegal_d;
      cnt_q     <= cnt_d;
    end
  end

  assign oValid      = valid_q;
  assign oOP         = op_q;
  assign oA          = a_q;
  assign oB          = b_q;
  assign oRd         = rd_q;
  assign oWe         = we_q;
  assign oIllegal    = illegal_q;
  assign oIllegalCnt = cnt_q;

endmodule

// File: tb/tb_rv_alu_decode.sv
// Scoreboard bench for rv_alu_decode: directed scenarios plus random traffic against a reference model.
module tb_rv_alu_decode;

  localparam int CNT_W = 8;
  localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;

  logic             iClk = 1'b0;
  logic             iRst;
  logic [31:0]      iInstr, iPC, iRs1Val, iRs2Val;
  logic             iInstrValid, iFlush, iReady;
  logic             oInstrReady, oValid, oWe, oIllegal;
  logic [3:0]       oOP;
  logic [31:0]      oA, oB;
  logic [4:0]       oRd;
  logic [CNT_W-1:0] oIllegalCnt;

  always #5 iClk = ~iClk;

  rv_alu_decode #(.CNT_W(CNT_W)) dut (
    .iClk        (iClk),
    .iRst        (iRst),
    .iInstr      (iInstr),
    .iPC         (iPC),
    .iRs1Val     (iRs1Val),
    .iRs2Val     (iRs2Val),
    .iInstrValid (iInstrValid),
    .oInstrReady (oInstrReady),
    .iFlush      (iFlush),
    .oValid      (oValid),
    .iReady      (iReady),
    .oOP         (oOP),
    .oA          (oA),
    .oB          (oB),
    .oRd         (oRd),
    .oWe         (oWe),
    .oIllegal    (oIllegal),
    .oIllegalCnt (oIllegalCnt)
  );

  typedef struct packed {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic        we;
    logic        ill;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned model_cnt = 0;
  int          total = 0;
  int          bad = 0;

  // ALU code for each funct3 of the base (f7=0) register/immediate forms, nibble per f3.
  localparam logic [31:0] OP_BY_F3 = {4'd4, 4'd3, 4'd6, 4'd2, 4'd9, 4'd8, 4'd5, 4'd0};

  function automatic exp_t ref_model(logic [31:0] w, logic [31:0] pc, logic [31:0] r1,
                                     logic [31:0] r2);
    exp_t       e;
    logic [6:0] opc = w[6:0];
    logic [2:0] f3 = w[14:12];
    logic [6:0] f7 = w[31:25];
    int         base_op = int'(OP_BY_F3[int'(f3)*4 +: 4]);
    e = '{op: 4'd0, a: 32'd0, b: 32'd0, rd: w[11:7], we: 1'b0, ill: 1'b1};
    if (opc == 7'h33) begin
      if (f7 == 7'h00) begin
        e.ill = 0; e.op = 4'(base_op);
      end else if (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)) begin
        e.ill = 0; e.op = (f3 == 3'd0) ? 4'd1 : 4'd7;
      end
      if (!e.ill) begin e.a = r1; e.b = r2; end
    end else if (opc == 7'h13) begin
      if (f3 == 3'd1 || f3 == 3'd5) begin
        if (f7 == 7'h00) begin e.ill = 0; e.op = (f3 == 3'd1) ? 4'd5 : 4'd6; end
        else if (f7 == 7'h20 && f3 == 3'd5) begin e.ill = 0; e.op = 4'd7; end
        if (!e.ill) begin e.a = r1; e.b = 32'(w[24:20]); end
      end else begin
        e.ill = 0; e.op = 4'(base_op); e.a = r1; e.b = 32'($signed(w[31:20]));
      end
    end else if (opc == 7'h37 || opc == 7'h17) begin
      e.ill = 0;
      e.a = (opc == 7'h17) ? pc : 32'd0;
      e.b = w & 32'hFFFF_F000;
    end
    e.we = !e.ill && (w[11:7] != 5'd0);
    return e;
  endfunction

  function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endfunction

  // Monitor: compares the presented slot with the scoreboard head; pops on consumption.
  always @(negedge iClk) begin
    chk("valid", 32'(oValid), 32'(exp_q.size() != 0));
    chk("instr_ready", 32'(oInstrReady), 32'(!iFlush && (exp_q.size() == 0 || iReady)));
    chk("illegal_cnt", 32'(oIllegalCnt), model_cnt);
    if (oValid && exp_q.size() != 0) begin
      chk("op", 32'(oOP), 32'(exp_q[0].op));
      chk("a", oA, exp_q[0].a);
      chk("b", oB, exp_q[0].b);
      chk("rd", 32'(oRd), 32'(exp_q[0].rd));
      chk("we", 32'(oWe), 32'(exp_q[0].we));
      chk("illegal", 32'(oIllegal), 32'(exp_q[0].ill));
      if (iReady) void'(exp_q.pop_front());
    end
  end

  // Advance one clock; the scoreboard learns what the coming edge accepts.
  task automatic cycle();
    exp_t e;
    @(negedge iClk);
    #1;
    if (iRst) begin
      exp_q.delete();
      model_cnt = 0;
    end else if (iFlush) begin
      exp_q.delete();
    end else if (iInstrValid && exp_q.size() == 0) begin
      e = ref_model(iInstr, iPC, iRs1Val, iRs2Val);
      exp_q.push_back(e);
      if (e.ill && model_cnt < CNT_MAX) model_cnt++;
    end
    @(posedge iClk);
    #1;
  endtask

  task automatic chk_all_zero(string tag);
    chk({tag, "_valid"}, 32'(oValid), 0);
    chk({tag, "_op"}, 32'(oOP), 0);
    chk({tag, "_a"}, oA, 0);
    chk({tag, "_b"}, oB, 0);
    chk({tag, "_rd"}, 32'(oRd), 0);
    chk({tag, "_we"}, 32'(oWe), 0);
    chk({tag, "_ill"}, 32'(oIllegal), 0);
    chk({tag, "_cnt"}, 32'(oIllegalCnt), 0);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] w = $urandom;
    logic [6:0]  f7;
    case ($urandom_range(0, 5))
      0: w[6:0] = 7'h33;
      1: w[6:0] = 7'h13;
      2: w[6:0] = 7'h37;
      3: w[6:0] = 7'h17;
      4: w = 32'hFFFF_FFFF;
      default: ;
    endcase
    f7 = ($urandom_range(0, 3) == 0) ? 7'($urandom) : (($urandom_range(0, 1) == 0) ? 7'h00 : 7'h20);
    if (w[6:0] == 7'h33 || (w[6:0] == 7'h13 && (w[14:12] == 3'd1 || w[14:12] == 3'd5)))
      w[31:25] = f7;
    return w;
  endfunction

  initial begin
    iRst = 1; iInstr = 0; iPC = 0; iRs1Val = 0; iRs2Val = 0;
    iInstrValid = 0; iFlush = 0; iReady = 1;
    cycle(); cycle();
    iRst = 0;
    chk_all_zero("reset");

    // ADD x3,x1,x2
    iInstrValid = 1; iInstr = 32'h0020_81B3; iRs1Val = 5; iRs2Val = 7;
    cycle();
    iInstrValid = 0;
    chk("add_valid", 32'(oValid), 1);
    chk("add_op", 32'(oOP), 0);
    chk("add_a", oA, 5);
    chk("add_b", oB, 7);
    chk("add_rd", 32'(oRd), 3);
    chk("add_we", 32'(oWe), 1);

    // SRAI x1,x2,4 then SLLI with the alternate f7
    iInstrValid = 1; iInstr = 32'h4041_5093; iRs1Val = 32'h8000_0000;
    cycle();
    chk("srai_op", 32'(oOP), 7);
    chk("srai_b", oB, 4);
    iInstr = 32'h4031_1093;
    cycle();
    chk("slli_bad_ill", 32'(oIllegal), 1);
    chk("slli_bad_we", 32'(oWe), 0);
    chk("slli_bad_cnt", 32'(oIllegalCnt), 1);

    // AUIPC x5,0x12345
    iInstr = 32'h1234_5297; iPC = 32'h100;
    cycle();
    chk("auipc_op", 32'(oOP), 0);
    chk("auipc_a", oA, 32'h100);
    chk("auipc_b", oB, 32'h1234_5000);
    chk("auipc_rd", 32'(oRd), 5);

    // Stall three cycles with a new instruction waiting
    iReady = 0; iInstr = 32'h0020_81B3; iRs1Val = 11; iRs2Val = 22;
    for (int i = 0; i < 3; i++) begin
      #1 chk("stall_ready", 32'(oInstrReady), 0);
      cycle();
      chk("stall_hold_a", oA, 32'h100);
    end
    iReady = 1;
    for (int i = 0; i < 4; i++) begin
      iInstr = 32'h0000_0033 | (32'(i + 1) << 7); iRs1Val = 32'(i); iRs2Val = 32'(10 * i);
      cycle();
      chk("b2b_valid", 32'(oValid), 1);
      chk("b2b_rd", 32'(oRd), 32'(i + 1));
    end

    // Flush while holding and offered an instruction; it must be taken afterwards
    iFlush = 1; iInstr = 32'h00A0_0113;
    #1 chk("flush_ready", 32'(oInstrReady), 0);
    cycle();
    iFlush = 0;
    chk("flush_valid", 32'(oValid), 0);
    cycle();
    iInstrValid = 0;
    chk("post_flush_rd", 32'(oRd), 2);
    chk("post_flush_b", oB, 10);

    // Saturation of the illegal counter
    iInstrValid = 1; iInstr = 32'hFFFF_FFFF;
    for (int i = 0; i < 300; i++) cycle();
    chk("sat_cnt", 32'(oIllegalCnt), CNT_MAX);
    iRst = 1;
    cycle();
    iRst = 0; iInstrValid = 0;
    chk_all_zero("mid_reset");

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      iInstrValid = ($urandom_range(0, 9) < 7);
      iReady      = ($urandom_range(0, 9) < 7);
      iFlush      = ($urandom_range(0, 19) == 0);
      iRst        = ($urandom_range(0, 499) == 0);
      iInstr      = rand_instr();
      iPC         = $urandom;
      iRs1Val     = $urandom;
      iRs2Val     = $urandom;
      cycle();
    end
    iRst = 0; iFlush = 0; iInstrValid = 0; iReady = 1;
    cycle(); cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
